// File: rtl/delay_line_ctrl.sv
// delay_line_ctrl: per-sample sequencer for the 18-bit x 4096-word echo/comb
// delay memory. Each strobe reads the sample written `delay` strobes ago and
// writes back dry + feedback * delayed. The delayed sample is presented as
// the wet output.
// Build option DELAY_LINE_CLEAR_EN: after reset, sweep zeros into the whole
// memory before accepting samples.
//
// state | meaning
// CLEAR | zeroing memory, one word per cycle (DELAY_LINE_CLEAR_EN only)
// IDLE  | waiting for sample_strobe
// READ  | delayed-sample address on the bus, memory registers it
// CAPT  | ram_out valid; capture wet and compute the feedback mix
// WRITE | mix written at wr_ptr; wet published on out_sample

module delay_line_ctrl #(
    parameter int DATA_W = 18,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              sclr,
    input  logic              sample_strobe,
    input  logic [DATA_W-1:0] sample_in,
    input  logic [ADDR_W-1:0] delay,
    input  logic [7:0]        feedback,
    output logic [DATA_W-1:0] out_sample,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [DATA_W-1:0] ram_in,
    input  logic [DATA_W-1:0] ram_out
);

`ifdef DELAY_LINE_CLEAR_EN
    typedef enum logic [2:0] {CLEAR, IDLE, READ, CAPT, WRITE} state_t;
`else
    typedef enum logic [1:0] {IDLE, READ, CAPT, WRITE} state_t;
`endif

    // Product of an 18-bit signed sample and a 9-bit non-negative gain.
    localparam int PROD_W = DATA_W + 9;

    state_t            state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [DATA_W-1:0] sample_q;
    logic [ADDR_W-1:0] delay_q;
    logic [7:0]        fb_q;
    logic [DATA_W-1:0] wet_q;
    logic [DATA_W-1:0] mix_q;
`ifdef DELAY_LINE_CLEAR_EN
    logic [ADDR_W-1:0] clr_left;
`endif

    logic signed [PROD_W-1:0] wet_ext;
    logic signed [PROD_W-1:0] fb_ext;
    logic signed [PROD_W-1:0] sample_ext;
    logic signed [PROD_W-1:0] product;
    logic signed [PROD_W-1:0] scaled;
    logic signed [PROD_W-1:0] sum;
    logic                     sum_in_range;
    logic [DATA_W-1:0]        mix_next;

    // Feedback mix from the word currently on ram_out (valid in CAPT).
    // The sum is kept at full product width so it cannot overflow before
    // the saturation check.
    always_comb begin
        wet_ext      = PROD_W'($signed(ram_out));
        fb_ext       = {{(PROD_W-8){1'b0}}, fb_q};
        sample_ext   = PROD_W'($signed(sample_q));
        product      = wet_ext * fb_ext;
        scaled       = product >>> 8;
        sum          = sample_ext + scaled;
        sum_in_range = (&sum[PROD_W-1:DATA_W-1]) || ~(|sum[PROD_W-1:DATA_W-1]);
        if (sum_in_range)
            mix_next = sum[DATA_W-1:0];
        else if (sum[PROD_W-1])
            mix_next = {1'b1, {(DATA_W-1){1'b0}}};
        else
            mix_next = {1'b0, {(DATA_W-1){1'b1}}};
    end

    // Sequencer: state, pointers, latched request and registered outputs.
    always_ff @(posedge clk) begin
        if (sclr) begin
            wr_ptr     <= '0;
            out_sample <= '0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
            sample_q   <= '0;
            delay_q    <= '0;
            fb_q       <= '0;
            wet_q      <= '0;
            mix_q      <= '0;
`ifdef DELAY_LINE_CLEAR_EN
            clr_left   <= '1;
            state      <= CLEAR;
`else
            state      <= IDLE;
`endif
        end else begin
            out_valid <= 1'b0;
            if (sample_strobe && (state != IDLE))
                overrun <= 1'b1;
            case (state)
`ifdef DELAY_LINE_CLEAR_EN
                CLEAR: begin
                    if (clr_left == '0)
                        state <= IDLE;
                    else
                        clr_left <= clr_left - ADDR_W'(1);
                end
`endif
                IDLE: begin
                    if (sample_strobe) begin
                        sample_q <= sample_in;
                        delay_q  <= delay;
                        fb_q     <= feedback;
                        state    <= READ;
                    end
                end
                READ: begin
                    state <= CAPT;
                end
                CAPT: begin
                    wet_q <= ram_out;
                    mix_q <= mix_next;
                    state <= WRITE;
                end
                WRITE: begin
                    wr_ptr     <= wr_ptr + ADDR_W'(1);
                    out_sample <= wet_q;
                    out_valid  <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory bus decoded from registered state only; delay 0 reads wr_ptr
    // itself, i.e. the word about to be overwritten (a full-depth delay).
    always_comb begin
        ram_addr = '0;
        ram_wren = 1'b0;
        ram_in   = '0;
        case (state)
`ifdef DELAY_LINE_CLEAR_EN
            CLEAR: begin
                ram_addr = ~clr_left;
                ram_wren = 1'b1;
            end
`endif
            READ: begin
                ram_addr = wr_ptr - delay_q;
            end
            WRITE: begin
                ram_addr = wr_ptr;
                ram_wren = 1'b1;
                ram_in   = mix_q;
            end
            default: begin
                ram_addr = '0;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule
